// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
//   Synchronous single-port SRAM behind a one-command-at-a-time burst
//   controller. A command is a read or write burst of up to BurstMax beats with
//   an incrementing address that wraps at the top of the array. Write beats
//   honour a per-byte-lane mask and may stall on InValid. Read beats are issued
//   back to back and surface on OutData ReadLatency cycles after issue.
//
// Parameters
//   AddressSize  address width, depth = 2**AddressSize words
//   WordSize     data width (multiple of 8)
//   BurstMax     maximum beats per burst (power of two, 1..256)
//   ReadLatency  issue-to-OutValid delay, 1 or 2
//
// Ports
//   Clock        rising-edge clock
//   Reset        asynchronous active-high reset
//   bCE          active-low command strobe, taken when Ready=1
//   bWE          command type sampled with bCE: 0 = write, 1 = read
//   Address      burst start address
//   BurstLen     beat count (0 means 1, values above BurstMax clamp)
//   ByteEn       write-beat byte-lane mask
//   InData       write-beat data
//   InValid      write beat present
//   OutData      registered read data, holds when OutValid=0
//   OutValid     OutData carries a read beat
//   Ready        idle, a command may be presented
//   Done         one-cycle pulse as a burst completes
//
// Optional build macro SRAM_PARITY_EN
//   Stores an even-parity bit per byte lane. Adds InjectParity (inverts the
//   stored parity of enabled lanes on a write beat) and ParityErr (valid with
//   OutValid, high when any lane of the read word fails its parity).
// -----------------------------------------------------------------------------
module sram_burst_ctrl #(
    parameter int AddressSize = 18,
    parameter int WordSize    = 32,
    parameter int BurstMax    = 16,
    parameter int ReadLatency = 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        bCE,
    input  logic                        bWE,
    input  logic [AddressSize-1:0]      Address,
    input  logic [$clog2(BurstMax):0]   BurstLen,
    input  logic [WordSize/8-1:0]       ByteEn,
    input  logic [WordSize-1:0]         InData,
    input  logic                        InValid,
    output logic [WordSize-1:0]         OutData,
    output logic                        OutValid,
    output logic                        Ready,
    output logic                        Done
`ifdef SRAM_PARITY_EN
    ,
    input  logic                        InjectParity,
    output logic                        ParityErr
`endif
);

    localparam int ByteLanes = WordSize / 8;
    localparam int LenW      = $clog2(BurstMax) + 1;
    localparam int Depth     = 1 << AddressSize;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [AddressSize-1:0] addr_q, addr_d;
    logic [LenW-1:0]        left_q, left_d;
    logic [LenW-1:0]        len_eff;

    logic                   wr_beat;
    logic                   rd_issue;
    logic                   last_beat;
    logic                   wr_done_q;

    // One slot per latency stage; the last slot drives OutData/OutValid.
    logic [WordSize-1:0]    rd_data_q [ReadLatency];
    logic [ReadLatency-1:0] rd_vld_q;
    logic [ReadLatency-1:0] rd_last_q;

    logic [WordSize-1:0]    mem [Depth];

    assign Ready     = (state_q == IDLE);
    assign wr_beat   = (state_q == WRITE) && InValid;
    assign rd_issue  = (state_q == READ);
    assign last_beat = (left_q == LenW'(1));

    assign OutData   = rd_data_q[ReadLatency-1];
    assign OutValid  = rd_vld_q[ReadLatency-1];
    // The read flag reaches the final stage together with the final beat.
    assign Done      = wr_done_q | rd_last_q[ReadLatency-1];

    // Zero-length bursts still move one beat; oversize requests saturate.
    always_comb begin
        if (BurstLen == '0) begin
            len_eff = LenW'(1);
        end else if (BurstLen > LenW'(BurstMax)) begin
            len_eff = LenW'(BurstMax);
        end else begin
            len_eff = BurstLen;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        unique case (state_q)
            IDLE: begin
                if (!bCE) begin
                    addr_d  = Address;
                    left_d  = len_eff;
                    state_d = bWE ? READ : WRITE;
                end
            end
            WRITE: begin
                if (InValid) begin
                    addr_d = addr_q + AddressSize'(1);
                    left_d = left_q - LenW'(1);
                    if (last_beat) state_d = IDLE;
                end
            end
            READ: begin
                addr_d = addr_q + AddressSize'(1);
                left_d = left_q - LenW'(1);
                if (last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_last_q[ReadLatency-1]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            wr_done_q <= wr_beat && last_beat;
        end
    end

    // NOTE: the storage array has no reset; contents survive Reset and the
    // array maps onto a RAM macro only when it is free of reset logic.
    always_ff @(posedge Clock) begin
        if (wr_beat) begin
            for (int b = 0; b < ByteLanes; b++) begin
                if (ByteEn[b]) mem[addr_q][8*b +: 8] <= InData[8*b +: 8];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [ByteLanes-1:0]   par_mem [Depth];
    logic [ByteLanes-1:0]   rd_par_mis;
    logic [ReadLatency-1:0] perr_q;

    always_ff @(posedge Clock) begin
        if (wr_beat) begin
            for (int b = 0; b < ByteLanes; b++) begin
                if (ByteEn[b]) par_mem[addr_q][b] <= (^InData[8*b +: 8]) ^ InjectParity;
            end
        end
    end

    always_comb begin
        rd_par_mis = '0;
        for (int b = 0; b < ByteLanes; b++) begin
            rd_par_mis[b] = par_mem[addr_q][b] ^ (^mem[addr_q][8*b +: 8]);
        end
    end

    assign ParityErr = perr_q[ReadLatency-1];
`endif

    // Read pipeline: stage 0 is the registered RAM read, later stages only
    // delay it. Data registers load only with a valid beat so OutData holds.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < ReadLatency; k++) rd_data_q[k] <= '0;
            rd_vld_q  <= '0;
            rd_last_q <= '0;
`ifdef SRAM_PARITY_EN
            perr_q    <= '0;
`endif
        end else begin
            rd_vld_q[0]  <= rd_issue;
            rd_last_q[0] <= rd_issue && last_beat;
            if (rd_issue) begin
                rd_data_q[0] <= mem[addr_q];
`ifdef SRAM_PARITY_EN
                perr_q[0]    <= |rd_par_mis;
`endif
            end
            for (int k = 1; k < ReadLatency; k++) begin
                rd_vld_q[k]  <= rd_vld_q[k-1];
                rd_last_q[k] <= rd_last_q[k-1];
                if (rd_vld_q[k-1]) begin
                    rd_data_q[k] <= rd_data_q[k-1];
`ifdef SRAM_PARITY_EN
                    perr_q[k]    <= perr_q[k-1];
`endif
                end
            end
        end
    end

endmodule
